// File: rtl/conv_mul_rr_sched.sv
// Round-robin scheduler sharing one signed din0 x din1 multiplier between N_REQ lanes.
// Ports: ap_clk/ap_rst/ap_ce, req_valid/req_ready/req_a/req_b per lane,
//        mul_din0/mul_din1/mul_dout to the shared multiplier, res_valid/res_id/res_data out.
module conv_mul_rr_sched #(
    parameter int N_REQ      = 4,
    parameter int NUM_STAGE  = 1,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 24,
    parameter int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic                          ap_ce,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*din0_WIDTH-1:0]   req_a,
    input  logic [N_REQ*din1_WIDTH-1:0]   req_b,
    output logic [din0_WIDTH-1:0]         mul_din0,
    output logic [din1_WIDTH-1:0]         mul_din1,
    input  logic [dout_WIDTH-1:0]         mul_dout,
    output logic                          res_valid,
    output logic [ID_W-1:0]               res_id,
    output logic [dout_WIDTH-1:0]         res_data
);

    logic [ID_W-1:0]       last;
    logic [ID_W-1:0]       gnt_id;
    logic                  gnt_any;
    logic [N_REQ-1:0]      grant;
    logic [din0_WIDTH-1:0] opa;
    logic [din1_WIDTH-1:0] opb;
    logic                  s0_valid;
    logic [ID_W-1:0]       s0_id;
    logic                  pv [NUM_STAGE];
    logic [ID_W-1:0]       pid[NUM_STAGE];
    logic [dout_WIDTH-1:0] pd [NUM_STAGE];

    // Search starts just after the last granted lane, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        grant   = '0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any    = 1'b1;
                gnt_id     = ID_W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    assign req_ready = (ap_ce && !ap_rst) ? grant : '0;

    assign mul_din0  = opa;
    assign mul_din1  = opb;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            last     <= ID_W'(N_REQ - 1);
            opa      <= '0;
            opb      <= '0;
            s0_valid <= 1'b0;
            s0_id    <= '0;
        end else if (ap_ce) begin
            s0_valid <= gnt_any;
            if (gnt_any) begin
                opa   <= req_a[gnt_id*din0_WIDTH +: din0_WIDTH];
                opb   <= req_b[gnt_id*din1_WIDTH +: din1_WIDTH];
                s0_id <= gnt_id;
                last  <= gnt_id;
            end
        end
    end

    // Stage 0 samples the combinational product; later stages only delay it.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int s = 0; s < NUM_STAGE; s++) begin
                pv[s]  <= 1'b0;
                pid[s] <= '0;
                pd[s]  <= '0;
            end
        end else if (ap_ce) begin
            pv[0]  <= s0_valid;
            pid[0] <= s0_id;
            pd[0]  <= mul_dout;
            for (int s = 1; s < NUM_STAGE; s++) begin
                pv[s]  <= pv[s-1];
                pid[s] <= pid[s-1];
                pd[s]  <= pd[s-1];
            end
        end
    end

    assign res_valid = pv[NUM_STAGE-1];
    assign res_id    = pid[NUM_STAGE-1];
    assign res_data  = pd[NUM_STAGE-1];

endmodule

// File: tb/tb_conv_mul_rr_sched.sv
// Directed self-checking bench for conv_mul_rr_sched.
// Two instances: NUM_STAGE=1 (main) and NUM_STAGE=3 (latency check), shared stimulus.
module tb_conv_mul_rr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [3:0]  valid;
    logic [63:0] ra;
    logic [31:0] rb;

    logic [3:0]  rdy1, rdy3;
    logic [15:0] d0_1, d0_3;
    logic [7:0]  d1_1, d1_3;
    logic [23:0] mo_1, mo_3;
    logic        rv1, rv3;
    logic [1:0]  rid1, rid3;
    logic [23:0] rd1, rd3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Shared multiplier models: full-precision signed product.
    assign mo_1 = $signed({{8{d0_1[15]}}, d0_1}) * $signed({{16{d1_1[7]}}, d1_1});
    assign mo_3 = $signed({{8{d0_3[15]}}, d0_3}) * $signed({{16{d1_3[7]}}, d1_3});

    conv_mul_rr_sched #(.NUM_STAGE(1)) dut1 (
        .ap_clk(clk), .ap_rst(rst), .ap_ce(ce),
        .req_valid(valid), .req_ready(rdy1),
        .req_a(ra), .req_b(rb),
        .mul_din0(d0_1), .mul_din1(d1_1), .mul_dout(mo_1),
        .res_valid(rv1), .res_id(rid1), .res_data(rd1)
    );

    conv_mul_rr_sched #(.NUM_STAGE(3)) dut3 (
        .ap_clk(clk), .ap_rst(rst), .ap_ce(ce),
        .req_valid(valid), .req_ready(rdy3),
        .req_a(ra), .req_b(rb),
        .mul_din0(d0_3), .mul_din1(d1_3), .mul_dout(mo_3),
        .res_valid(rv3), .res_id(rid3), .res_data(rd3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        ce    = 1'b1;
        valid = '0;
        ra    = '0;
        rb    = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic set_lane(input int i, input int a, input int b);
        ra[i*16 +: 16] = 16'(a);
        rb[i*8 +: 8]   = 8'(b);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        ce    = 1'b1;
        valid = 4'b1111;
        #2;
        total++;
        if (rdy1 !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ready got=%b want=0000", rdy1);
        end
        tick();
        total++;
        if ({rv1, rid1, rd1, d0_1, d1_1} !== '0) begin
            bad++;
            $display("FAIL reset_state got v=%b id=%0d d=%h m0=%h m1=%h want all 0",
                     rv1, rid1, rd1, d0_1, d1_1);
        end
        valid = '0;
        rst   = 1'b0;
        #1;
    endtask

    task automatic test_single();
        do_reset();
        set_lane(0, 3, -2);
        valid = 4'b0001;
        #1;
        total++;
        if (rdy1 !== 4'b0001) begin
            bad++;
            $display("FAIL single_ready got=%b want=0001", rdy1);
        end
        tick();
        valid = 4'b0000;
        total++;
        if (d0_1 !== 16'd3 || d1_1 !== 8'hFE) begin
            bad++;
            $display("FAIL single_muldin got=%h/%h want=0003/fe", d0_1, d1_1);
        end
        total++;
        if (rv1 !== 1'b0) begin
            bad++;
            $display("FAIL single_early got=%b want=0", rv1);
        end
        tick();
        total++;
        if (rv1 !== 1'b1 || rid1 !== 2'd0 || rd1 !== 24'hFFFFFA) begin
            bad++;
            $display("FAIL single_res got v=%b id=%0d d=%h want 1/0/fffffa",
                     rv1, rid1, rd1);
        end
        tick();
        total++;
        if (rv1 !== 1'b0) begin
            bad++;
            $display("FAIL single_pulse got=%b want=0", rv1);
        end
    endtask

    task automatic test_round_robin();
        int ea[4] = '{1000, 2000, 3000, 4000};
        int eb[4] = '{-3, -6, -9, -12};
        logic [23:0] exp;
        do_reset();
        for (int i = 0; i < 4; i++) set_lane(i, ea[i], eb[i]);
        for (int c = 0; c < 9; c++) begin
            valid = (c < 8) ? 4'b1111 : 4'b0100;
            #1;
            total++;
            if (c < 8 && rdy1 !== 4'(1 << (c % 4))) begin
                bad++;
                $display("FAIL rr_grant c=%0d got=%b want=%b",
                         c, rdy1, 4'(1 << (c % 4)));
            end
            tick();
            if (c >= 1) begin
                exp = 24'(ea[(c-1)%4] * eb[(c-1)%4]);
                total++;
                if (rv1 !== 1'b1 || rid1 !== 2'((c-1)%4) || rd1 !== exp) begin
                    bad++;
                    $display("FAIL rr_res c=%0d got v=%b id=%0d d=%h want 1/%0d/%h",
                             c, rv1, rid1, rd1, (c-1)%4, exp);
                end
            end
        end
        for (int c = 0; c < 3; c++) begin
            valid = 4'b0100;
            #1;
            total++;
            if (rdy1 !== 4'b0100) begin
                bad++;
                $display("FAIL rr_only2 c=%0d got=%b want=0100", c, rdy1);
            end
            tick();
        end
        valid = '0;
        tick();
        tick();
    endtask

    task automatic test_corners();
        int ca[4] = '{-32768, -32768, 32767, 0};
        int cb[4] = '{-128, 127, 127, -128};
        logic [23:0] ce_exp[4] = '{24'h400000, 24'hC08000, 24'h3F7F81, 24'h000000};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if (c < 4) begin
                set_lane(0, ca[c], cb[c]);
                valid = 4'b0001;
            end else begin
                valid = 4'b0000;
            end
            tick();
            if (c >= 1) begin
                total++;
                if (rv1 !== 1'b1 || rd1 !== ce_exp[c-1]) begin
                    bad++;
                    $display("FAIL corner%0d got v=%b d=%h want 1/%h",
                             c-1, rv1, rd1, ce_exp[c-1]);
                end
            end
        end
        tick();
    endtask

    task automatic test_ce_stall();
        do_reset();
        set_lane(0, 5, 6);
        valid = 4'b0001;
        tick();
        set_lane(0, 7, 8);
        tick();
        total++;
        if (rv1 !== 1'b1 || rd1 !== 24'd30) begin
            bad++;
            $display("FAIL stall_first got v=%b d=%h want 1/00001e", rv1, rd1);
        end
        ce = 1'b0;
        set_lane(0, 9, 9);
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (rdy1 !== 4'b0000) begin
                bad++;
                $display("FAIL stall_ready c=%0d got=%b want=0000", c, rdy1);
            end
            tick();
            total++;
            if (rv1 !== 1'b1 || rd1 !== 24'd30 || d0_1 !== 16'd7) begin
                bad++;
                $display("FAIL stall_hold c=%0d got v=%b d=%h m0=%h want 1/00001e/0007",
                         c, rv1, rd1, d0_1);
            end
        end
        valid = '0;
        ce    = 1'b1;
        tick();
        total++;
        if (rv1 !== 1'b1 || rid1 !== 2'd0 || rd1 !== 24'd56) begin
            bad++;
            $display("FAIL stall_resume got v=%b id=%0d d=%h want 1/0/000038",
                     rv1, rid1, rd1);
        end
        tick();
        total++;
        if (rv1 !== 1'b0) begin
            bad++;
            $display("FAIL stall_nodup got=%b want=0", rv1);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_lane(0, 11, 2);
        valid = 4'b0001;
        tick();
        set_lane(0, 13, 3);
        tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (rv1 !== 1'b0 || rd1 !== '0 || d0_1 !== '0 || d1_1 !== '0
            || rdy1 !== '0) begin
            bad++;
            $display("FAIL arst_now got v=%b d=%h m0=%h m1=%h r=%b want all 0",
                     rv1, rd1, d0_1, d1_1, rdy1);
        end
        valid = '0;
        tick();
        rst = 1'b0;
        #1;
        tick();
        total++;
        if (rv1 !== 1'b0) begin
            bad++;
            $display("FAIL arst_stale got=%b want=0", rv1);
        end
        valid = 4'b1001;
        #1;
        total++;
        if (rdy1 !== 4'b0001) begin
            bad++;
            $display("FAIL arst_first got=%b want=0001", rdy1);
        end
        valid = '0;
        tick();
    endtask

    task automatic test_stage3();
        do_reset();
        set_lane(0, -4, 5);
        valid = 4'b0001;
        tick();
        valid = '0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            total++;
            if (c == 3) begin
                if (rv3 !== 1'b1 || rid3 !== 2'd0 || rd3 !== 24'hFFFFEC) begin
                    bad++;
                    $display("FAIL s3_res got v=%b id=%0d d=%h want 1/0/ffffec",
                             rv3, rid3, rd3);
                end
            end else if (rv3 !== 1'b0) begin
                bad++;
                $display("FAIL s3_timing edge+%0d got=%b want=0", c, rv3);
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        set_lane(0, 2, 2);
        set_lane(1, 3, 3);
        set_lane(2, 4, 4);
        valid = 4'b0011;
        #1;
        total++;
        if (rdy1 !== 4'b0001) begin
            bad++;
            $display("FAIL drop_first got=%b want=0001", rdy1);
        end
        tick();
        valid = 4'b0000;
        tick();
        total++;
        if (rv1 !== 1'b1 || rid1 !== 2'd0) begin
            bad++;
            $display("FAIL drop_res0 got v=%b id=%0d want 1/0", rv1, rid1);
        end
        valid = 4'b0111;
        #1;
        total++;
        if (rdy1 !== 4'b0010) begin
            bad++;
            $display("FAIL drop_ptr got=%b want=0010", rdy1);
        end
        tick();
        valid = '0;
        total++;
        if (rv1 !== 1'b0) begin
            bad++;
            $display("FAIL drop_noacc got=%b want=0", rv1);
        end
        tick();
        total++;
        if (rv1 !== 1'b1 || rid1 !== 2'd1 || rd1 !== 24'd9) begin
            bad++;
            $display("FAIL drop_res1 got v=%b id=%0d d=%h want 1/1/000009",
                     rv1, rid1, rd1);
        end
    endtask

    initial begin
        rst   = 1'b1;
        ce    = 1'b1;
        valid = '0;
        ra    = '0;
        rb    = '0;
        #3;
        test_reset();
        test_single();
        test_round_robin();
        test_corners();
        test_ce_stall();
        test_async_reset();
        test_stage3();
        test_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_mul_rr_sched.md
Name: conv_mul_rr_sched

Overview:
- Round-robin scheduler that shares one signed 16x8 -> 24 convolution multiplier between N_REQ requesters (conv channel lanes).
- Accepts operand pairs over per-requester valid/ready handshakes and drives the external combinational multiplier instance.
- Returns each product registered and tagged with the ID of the requester that issued it.
- Sits between the conv lane FSMs and the single shared conv multiplier.

Parameters:
N_REQ, 4, number of requesters (2..8)
NUM_STAGE, 1, product register stages after the multiplier (>=1)
din0_WIDTH, 16, operand A width, signed
din1_WIDTH, 8, operand B width, signed
dout_WIDTH, 24, product width, signed, = din0_WIDTH+din1_WIDTH
ID_W, 2, res_id width, = max(1, clog2(N_REQ))

Ports:
ap_clk  in  1  clock, all state on rising edge
ap_rst  in  1  reset, asynchronous, active-high
ap_ce  in  1  pipeline enable; low freezes the whole block
req_valid  in  N_REQ  bit i: requester i has an operand pair
req_ready  out  N_REQ  bit i: requester i granted this cycle
req_a  in  N_REQ*din0_WIDTH  packed operand A, lane i at [i*16 +: 16]
req_b  in  N_REQ*din1_WIDTH  packed operand B, lane i at [i*8 +: 8]
mul_din0  out  din0_WIDTH  to shared multiplier din0
mul_din1  out  din1_WIDTH  to shared multiplier din1
mul_dout  in  dout_WIDTH  from shared multiplier dout (combinational)
res_valid  out  1  result valid, one-cycle pulse per product
res_id  out  ID_W  requester index of the result
res_data  out  dout_WIDTH  signed product

Behaviour:
- Reset (ap_rst high, async):
  - All valid bits clear; res_valid=0, res_id=0, res_data=0.
  - mul_din0=0, mul_din1=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has top priority first.
  - req_ready=0 while ap_rst is high.
  - In-flight operations are discarded with no result. No outputs go X.
- Arbitration (combinational):
  - Search order is last+1, last+2, ... modulo N_REQ.
  - The first i with req_valid[i]=1 is granted.
  - req_ready[i] = ap_ce & grant[i]; at most one bit is high. req_ready may depend on req_valid.
- Accept:
  - An accept is req_valid[i] & req_ready[i] at a rising edge.
  - On accept: operand register <= {req_a lane i, req_b lane i}, s0_valid<=1, s0_id<=i, last<=i.
  - With no accept and ap_ce=1: s0_valid<=0, and last is unchanged.
- Datapath:
  - mul_din0/mul_din1 are driven directly from the operand register.
  - Product register stage 1 captures mul_dout with s0_valid and s0_id.
  - Stages 2..NUM_STAGE are plain delay registers.
  - The last stage drives res_valid, res_id and res_data.
- Latency and throughput:
  - Accept at edge k -> res_valid=1 in the cycle following edge k+NUM_STAGE, i.e. NUM_STAGE+1 edges.
  - Throughput is one product per cycle. Results leave in accept order.
- ap_ce=0:
  - req_ready is all zero. No register changes; every valid bit, id, data and last holds.
  - res_valid stays at its held value.
  - When ap_ce returns to 1, the pipeline resumes exactly where it stopped. Consumers qualify res_valid with ap_ce.
- Arithmetic:
  - Full-precision signed product; no truncation or saturation.
  - Worst case -32768 * -128 = +4194304 = 0x400000 fits in 24 bits.
  - res_data is an exact copy of mul_dout, delayed.
- Fairness and stability:
  - A continuously valid requester is granted within N_REQ cycles while ap_ce=1.
  - A requester dropping req_valid before it is granted causes no accept and no state change.
  - Requesters hold their operands stable only during the cycle they assert valid; the block samples them only on accept.
- No result backpressure: the consumer must take every res_valid pulse.

Test Plan:
- Single request, req0 a=3 b=-2, NUM_STAGE=1 -> req_ready[0] in the same cycle; mul_din0=3 and mul_din1=-2 after the edge; res_valid one cycle later with res_id=0 and res_data=0xFFFFFA; res_valid low in the next cycle.
- All four req_valid held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3; back-to-back res_valid for 8 cycles with matching res_id order; then only req2 valid -> req2 granted every cycle.
- Corner products: (-32768,-128) -> 0x400000; (-32768,127) -> 0xC08000; (32767,127) -> 0x3F7F81; (0,-128) -> 0x000000.
- ap_ce low for 3 cycles while 2 products are in flight -> req_ready=0 and outputs hold throughout; on ap_ce high the remaining results emerge in order with no loss or duplication.
- Assert ap_rst asynchronously mid-edge-period with 2 products in flight -> res_valid, res_data and mul_din* are 0 immediately; no stale result after release; the first grant after reset goes to req0 when req0 and req3 are both valid.
- NUM_STAGE=3, accept at edge k -> res_valid exactly after edge k+3; req1 dropping valid before grant -> no accept, pointer unchanged.
